// File: rtl/instr_fetch_unit_if.sv
// Fetch-unit bundle: redirect input, imem request/response channels, decode output.
// master = fetch unit side, slave = environment (imem + decode + branch unit).
interface instr_fetch_unit_if;
  logic        redirect_valid;
  logic [15:0] redirect_pc;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [15:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [15:0] imem_rsp_data;
  logic        instr_valid;
  logic        instr_ready;
  logic [15:0] instr;
  logic [15:0] instr_pc;

  modport master (
    input  redirect_valid, redirect_pc, imem_req_ready, imem_rsp_valid, imem_rsp_data, instr_ready,
    output imem_req_valid, imem_req_addr, instr_valid, instr, instr_pc
  );
  modport slave (
    output redirect_valid, redirect_pc, imem_req_ready, imem_rsp_valid, imem_rsp_data, instr_ready,
    input  imem_req_valid, imem_req_addr, instr_valid, instr, instr_pc
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// Sequential-PC fetch stage with credit-limited prefetch FIFO and redirect/flush.
// Define FETCH_PERF_EN to add the stall_cycles counter output.
module instr_fetch_unit #(
  parameter int          DEPTH    = 4,
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic                 clk,
  input  logic                 rst,
  instr_fetch_unit_if.master   bus
`ifdef FETCH_PERF_EN
  ,
  output logic [15:0]          stall_cycles
`endif
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef struct packed {
    logic [15:0] pc;
    logic [15:0] ins;
  } entry_t;

  entry_t        r_fifo [DEPTH];
  logic [CW-1:0] r_wptr, r_rptr, r_inflight, r_drop_cnt;
  logic [15:0]   r_fetch_pc, r_rsp_pc;

  logic [CW-1:0] w_count;
  logic [CW:0]   w_credit;
  logic          w_req_valid, w_req_fire, w_rsp_ok, w_push, w_pop;
  logic [15:0]   w_redir_pc;
  entry_t        w_head;

  assign w_count     = r_wptr - r_rptr;
  // Outstanding requests plus buffered words can never exceed the FIFO size,
  // so every response always has a slot waiting for it.
  assign w_credit    = {1'b0, r_inflight} + {1'b0, w_count};
  assign w_req_valid = !rst && !bus.redirect_valid && (w_credit < (CW+1)'(DEPTH));
  assign w_req_fire  = w_req_valid && bus.imem_req_ready;
  assign w_rsp_ok    = bus.imem_rsp_valid && (r_inflight != '0);
  assign w_push      = w_rsp_ok && (r_drop_cnt == '0);
  assign w_pop       = bus.instr_valid && bus.instr_ready;
  assign w_redir_pc  = {bus.redirect_pc[15:1], 1'b0};
  assign w_head      = r_fifo[r_rptr[AW-1:0]];

  assign bus.imem_req_valid = w_req_valid;
  assign bus.imem_req_addr  = r_fetch_pc;
  assign bus.instr_valid    = !rst && (w_count != '0);
  assign bus.instr          = w_head.ins;
  assign bus.instr_pc       = w_head.pc;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_fetch_pc <= RESET_PC;
      r_rsp_pc   <= RESET_PC;
      r_inflight <= '0;
      r_drop_cnt <= '0;
      r_wptr     <= '0;
      r_rptr     <= '0;
    end else if (bus.redirect_valid) begin
      // Everything still in flight belongs to the old path; a response landing
      // this cycle is already accounted for and simply dropped.
      r_fetch_pc <= w_redir_pc;
      r_rsp_pc   <= w_redir_pc;
      r_rptr     <= r_wptr;
      r_inflight <= r_inflight - CW'(w_rsp_ok);
      r_drop_cnt <= r_inflight - CW'(w_rsp_ok);
    end else begin
      r_inflight <= r_inflight + CW'(w_req_fire) - CW'(w_rsp_ok);
      if (w_req_fire) r_fetch_pc <= r_fetch_pc + 16'd2;
      if (w_rsp_ok && (r_drop_cnt != '0)) r_drop_cnt <= r_drop_cnt - 1'b1;
      if (w_push) begin
        r_wptr   <= r_wptr + 1'b1;
        r_rsp_pc <= r_rsp_pc + 16'd2;
      end
      if (w_pop) r_rptr <= r_rptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && !bus.redirect_valid && w_push)
      r_fifo[r_wptr[AW-1:0]] <= '{pc: r_rsp_pc, ins: bus.imem_rsp_data};
  end

`ifdef FETCH_PERF_EN
  logic [15:0] r_stall_cycles;

  always_ff @(posedge clk) begin
    if (rst)
      r_stall_cycles <= '0;
    else if (bus.instr_ready && !bus.instr_valid && (r_stall_cycles != 16'hFFFF))
      r_stall_cycles <= r_stall_cycles + 16'd1;
  end

  assign stall_cycles = r_stall_cycles;
`endif
endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: cycle table for start-up/backpressure,
// hand sequences for redirect, request stall, wrap-around and the perf counter.
module tb_instr_fetch_unit;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  instr_fetch_unit_if bus();
  instr_fetch_unit_if bus2();

`ifdef FETCH_PERF_EN
  logic [15:0] stall_cycles, stall_cycles2;
`endif

  instr_fetch_unit #(.DEPTH(4), .RESET_PC(16'h0000)) dut (
    .clk(clk), .rst(rst), .bus(bus)
`ifdef FETCH_PERF_EN
    , .stall_cycles(stall_cycles)
`endif
  );

  instr_fetch_unit #(.DEPTH(4), .RESET_PC(16'hFFFC)) dut2 (
    .clk(clk), .rst(rst), .bus(bus2)
`ifdef FETCH_PERF_EN
    , .stall_cycles(stall_cycles2)
`endif
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Memory for dut: in-order, latency `lat` cycles, data = addr ^ A5A5.
  typedef struct {
    logic [15:0] addr;
    int          due;
  } pend_t;
  pend_t q[$];
  int    lat = 1;
  int    cyc = 0;
  bit    inj = 1'b0;

  initial begin
    logic hs, r;
    logic [15:0] a;
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_data  = 16'h0;
    forever begin
      @(negedge clk); #4;
      hs = bus.imem_req_valid && bus.imem_req_ready;
      a  = bus.imem_req_addr;
      r  = rst;
      @(posedge clk); #1;
      cyc++;
      if (r === 1'b1) q.delete();
      else if (hs === 1'b1) q.push_back('{a, cyc + lat - 1});
      if (inj) begin
        bus.imem_rsp_valid = 1'b1;
        bus.imem_rsp_data  = 16'hDEAD;
      end else if (r !== 1'b1 && q.size() > 0 && q[0].due <= cyc) begin
        bus.imem_rsp_valid = 1'b1;
        bus.imem_rsp_data  = q[0].addr ^ 16'hA5A5;
        void'(q.pop_front());
      end else begin
        bus.imem_rsp_valid = 1'b0;
      end
    end
  end

  // Memory for dut2: always ready, fixed 1-cycle latency.
  initial begin
    logic hs, r;
    logic [15:0] a;
    bus2.imem_rsp_valid = 1'b0;
    bus2.imem_rsp_data  = 16'h0;
    forever begin
      @(negedge clk); #4;
      hs = bus2.imem_req_valid && bus2.imem_req_ready;
      a  = bus2.imem_req_addr;
      r  = rst;
      @(posedge clk); #1;
      bus2.imem_rsp_valid = (hs === 1'b1) && (r !== 1'b1);
      bus2.imem_rsp_data  = a ^ 16'hA5A5;
    end
  end

  // Bounded wait for the next instruction; consumes it (instr_ready is held high).
  task automatic expect_next(input logic [15:0] pc);
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      #1;
      if (bus.instr_valid === 1'b1) begin
        seen = 1'b1;
        chk("next_pc", bus.instr_pc, pc);
        chk("next_instr", bus.instr, pc ^ 16'hA5A5);
      end
      @(negedge clk);
    end
    if (!seen) begin
      n_cmp++;
      n_bad++;
      $display("FAIL next_valid_timeout: instr_valid never seen, expected pc %h", pc);
    end
  endtask

  typedef struct {
    logic        rst;
    logic        rdy;
    logic        rv;
    logic [15:0] addr;
    logic        iv;
    logic [15:0] pc;
    logic        iv2;
    logic [15:0] pc2;
  } vec_t;
  vec_t tv[17];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    //        rst   rdy   req  addr      iv    pc        iv2   pc2
    tv[0]  = '{1'b1, 1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000};
    tv[1]  = '{1'b0, 1'b1, 1'b1, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000};
    tv[2]  = '{1'b0, 1'b1, 1'b1, 16'h0002, 1'b0, 16'h0000, 1'b0, 16'h0000};
    tv[3]  = '{1'b0, 1'b1, 1'b1, 16'h0004, 1'b1, 16'h0000, 1'b1, 16'hFFFC};
    tv[4]  = '{1'b0, 1'b1, 1'b1, 16'h0006, 1'b1, 16'h0002, 1'b1, 16'hFFFE};
    tv[5]  = '{1'b0, 1'b1, 1'b1, 16'h0008, 1'b1, 16'h0004, 1'b1, 16'h0000};
    tv[6]  = '{1'b0, 1'b0, 1'b1, 16'h000A, 1'b1, 16'h0006, 1'b1, 16'h0002};
    tv[7]  = '{1'b0, 1'b0, 1'b1, 16'h000C, 1'b1, 16'h0006, 1'b1, 16'h0004};
    tv[8]  = '{1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 16'h0006, 1'b1, 16'h0006};
    tv[9]  = '{1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 16'h0006, 1'b1, 16'h0008};
    tv[10] = '{1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 16'h0006, 1'b1, 16'h000A};
    tv[11] = '{1'b0, 1'b1, 1'b0, 16'h0000, 1'b1, 16'h0006, 1'b1, 16'h000C};
    tv[12] = '{1'b0, 1'b1, 1'b1, 16'h000E, 1'b1, 16'h0008, 1'b1, 16'h000E};
    tv[13] = '{1'b0, 1'b1, 1'b1, 16'h0010, 1'b1, 16'h000A, 1'b1, 16'h0010};
    tv[14] = '{1'b0, 1'b1, 1'b1, 16'h0012, 1'b1, 16'h000C, 1'b1, 16'h0012};
    tv[15] = '{1'b0, 1'b1, 1'b1, 16'h0014, 1'b1, 16'h000E, 1'b1, 16'h0014};
    tv[16] = '{1'b0, 1'b1, 1'b1, 16'h0016, 1'b1, 16'h0010, 1'b1, 16'h0016};

    rst = 1'b1;
    bus.redirect_valid  = 1'b0; bus.redirect_pc  = 16'h0;
    bus.imem_req_ready  = 1'b1; bus.instr_ready  = 1'b1;
    bus2.redirect_valid = 1'b0; bus2.redirect_pc = 16'h0;
    bus2.imem_req_ready = 1'b1; bus2.instr_ready = 1'b1;
    repeat (2) @(negedge clk);

    // Start-up, throughput, backpressure to a full FIFO and release; dut2 wraps.
    for (int i = 0; i < 17; i++) begin
      rst = tv[i].rst;
      bus.instr_ready = tv[i].rdy;
      #1;
      chk1($sformatf("t%0d_req_valid", i), bus.imem_req_valid, tv[i].rv);
      if (tv[i].rv) chk($sformatf("t%0d_req_addr", i), bus.imem_req_addr, tv[i].addr);
      chk1($sformatf("t%0d_instr_valid", i), bus.instr_valid, tv[i].iv);
      if (tv[i].iv) begin
        chk($sformatf("t%0d_instr_pc", i), bus.instr_pc, tv[i].pc);
        chk($sformatf("t%0d_instr", i), bus.instr, tv[i].pc ^ 16'hA5A5);
      end
      chk1($sformatf("t%0d_instr_valid2", i), bus2.instr_valid, tv[i].iv2);
      if (tv[i].iv2) begin
        chk($sformatf("t%0d_instr_pc2", i), bus2.instr_pc, tv[i].pc2);
        chk($sformatf("t%0d_instr2", i), bus2.instr, tv[i].pc2 ^ 16'hA5A5);
      end
      @(negedge clk);
    end

    // Redirect with two slow responses outstanding.
    lat = 3;
    bus.instr_ready = 1'b1;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1; chk1("rd_A_req_valid", bus.imem_req_valid, 1'b1); chk("rd_A_addr", bus.imem_req_addr, 16'h0000);
    @(negedge clk);
    #1; chk1("rd_B_req_valid", bus.imem_req_valid, 1'b1); chk("rd_B_addr", bus.imem_req_addr, 16'h0002);
    @(negedge clk);
    bus.redirect_valid = 1'b1; bus.redirect_pc = 16'h0100;
    #1; chk1("rd_C_req_valid", bus.imem_req_valid, 1'b0);
    @(negedge clk);
    bus.redirect_valid = 1'b0;
    #1; chk1("rd_D_req_valid", bus.imem_req_valid, 1'b1); chk("rd_D_addr", bus.imem_req_addr, 16'h0100);
    for (int k = 0; k < 4; k++) begin
      #1; chk1($sformatf("rd_drop%0d_valid", k), bus.instr_valid, 1'b0);
      @(negedge clk);
    end
    #1; chk1("rd_H_valid", bus.instr_valid, 1'b1);
    chk("rd_H_pc", bus.instr_pc, 16'h0100); chk("rd_H_instr", bus.instr, 16'hA4A5);
    @(negedge clk);

    // Back-to-back redirects, the last one to an odd address; responses arrive in both cycles.
    bus.redirect_valid = 1'b1; bus.redirect_pc = 16'h0200;
    #1; chk1("rd2_I_req_valid", bus.imem_req_valid, 1'b0);
    @(negedge clk);
    bus.redirect_pc = 16'h0101;
    #1; chk1("rd2_J_flushed", bus.instr_valid, 1'b0);
    @(negedge clk);
    bus.redirect_valid = 1'b0;
    #1; chk("rd2_K_addr", bus.imem_req_addr, 16'h0100);
    expect_next(16'h0100);
    expect_next(16'h0102);
    expect_next(16'h0104);

    // Request channel stall plus a spurious response with nothing in flight.
    lat = 1;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    bus.imem_req_ready = 1'b0;
    inj = 1'b1;
    #1; chk1("st1_req_valid", bus.imem_req_valid, 1'b1); chk("st1_addr", bus.imem_req_addr, 16'h0000);
    @(negedge clk);
    inj = 1'b0;
    #1; chk1("st2_req_valid", bus.imem_req_valid, 1'b1); chk("st2_addr", bus.imem_req_addr, 16'h0000);
    @(negedge clk);
    #1; chk1("st3_req_valid", bus.imem_req_valid, 1'b1); chk("st3_addr", bus.imem_req_addr, 16'h0000);
    chk1("st3_spurious_ignored", bus.instr_valid, 1'b0);
    @(negedge clk);
    bus.imem_req_ready = 1'b1;
    for (int k = 0; k < 2; k++) begin
      #1; chk1($sformatf("st_go%0d_req_valid", k), bus.imem_req_valid, 1'b1);
      chk($sformatf("st_go%0d_addr", k), bus.imem_req_addr, 16'(2 * k));
      @(negedge clk);
    end
    expect_next(16'h0000);
    expect_next(16'h0002);
    expect_next(16'h0004);

`ifdef FETCH_PERF_EN
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    bus.imem_req_ready = 1'b0;
    bus.instr_ready = 1'b1;
    repeat (5) @(negedge clk);
    #1; chk("perf_stall5", stall_cycles, 16'd5);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    #1; chk("perf_cleared", stall_cycles, 16'd0);
    @(negedge clk);
    rst = 1'b0;
    bus.imem_req_ready = 1'b1;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
